text_pixel_serializer: RTL

Back-end stage of the VGA text path: consumes the font ROM word addressed by the character data generator and turns it into one RGB pixel per pixel tick. Delays video_on, hsync and vsync by the same latency as the address/ROM path so colour and sync leave aligned. Adds frame-synchronous foreground colour update and a frame-counted blink. Sits between the font ROM and the VGA DAC/output pins.

---
 rtl/vga_text_pkg.sv | 38 +++
 rtl/tick_delay_line.sv | 38 +++
 rtl/text_pixel_serializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared constants and types for the VGA text back end.
// Colour format, sync polarity and font geometry live here.
package vga_text_pkg;

  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] FG_DEFAULT = 12'hFFF;
  localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam int FONT_W = 8;
  localparam int BIT_AW = $clog2(FONT_W);

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
    logic [BIT_AW-1:0] bit_addr;
  } pix_ctl_t;

  localparam int CTL_W = $bits(pix_ctl_t);

  localparam pix_ctl_t CTL_IDLE = '{
    video_on: 1'b0,
    hsync:    ~SYNC_ACTIVE,
    vsync:    ~SYNC_ACTIVE,
    bit_addr: '0
  };

  // Font rows are stored MSB-first: column 0 is bit FONT_W-1.
  function automatic logic font_bit(
    input logic [FONT_W-1:0] word,
    input logic [BIT_AW-1:0] addr
  );
    logic [BIT_AW-1:0] idx;
    idx = BIT_AW'(FONT_W - 1) - addr;
    return word[idx];
  endfunction

endpackage

// File: rtl/tick_delay_line.sv
// tick_delay_line: DEPTH-stage shift register that advances only
// when en is high; all stages reset to RESET_VAL.
module tick_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_serializer.sv
// text_pixel_serializer: font word to RGB pixel with aligned syncs,
// frame-synchronous foreground update and frame-counted blink.
module text_pixel_serializer #(
  parameter int ADDR_LAT = 2,
  parameter int COLOR_W = vga_text_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] FG_DEFAULT = vga_text_pkg::FG_DEFAULT,
  parameter logic [COLOR_W-1:0] BG_COLOR = vga_text_pkg::BG_COLOR,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pixel_tick,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [9:0]         pixel_x,
  input  logic [7:0]         font_word,
  input  logic [COLOR_W-1:0] color_fg_in,
  input  logic               color_load,
  input  logic               blink_en,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               pixel_valid
);

  import vga_text_pkg::pix_ctl_t;
  import vga_text_pkg::CTL_W;
  import vga_text_pkg::CTL_IDLE;
  import vga_text_pkg::SYNC_ACTIVE;
  import vga_text_pkg::BIT_AW;
  import vga_text_pkg::font_bit;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  pix_ctl_t ctl_in;
  pix_ctl_t ctl_out;
  logic     unused_px_hi;

  assign ctl_in = '{
    video_on: video_on,
    hsync:    hsync_in,
    vsync:    vsync_in,
    bit_addr: pixel_x[BIT_AW-1:0]
  };
  assign unused_px_hi = ^pixel_x[9:BIT_AW];

  tick_delay_line #(
    .DEPTH     (ADDR_LAT),
    .WIDTH     (CTL_W),
    .RESET_VAL (CTL_IDLE)
  ) u_ctl_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pixel_tick),
    .din     (ctl_in),
    .dout    (ctl_out)
  );

  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               valid_q, valid_d;
  logic [COLOR_W-1:0] fg_active_q, fg_active_d;
  logic [COLOR_W-1:0] fg_shadow_q, fg_shadow_d;
  logic               pending_q, pending_d;
  logic [7:0]         blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  logic               frame_edge;
  logic               pix_on;

  // vsync_q still holds the previous pixel's vsync, so this is the
  // falling edge seen at the output-stage input.
  assign frame_edge = pixel_tick
                    && (vsync_q != SYNC_ACTIVE)
                    && (ctl_out.vsync == SYNC_ACTIVE);

  always_comb begin
    pix_on = font_bit(font_word, ctl_out.bit_addr)
           && !(blink_en && blink_off_q);
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    valid_d = valid_q;
    if (pixel_tick) begin
      if (!ctl_out.video_on) begin
        rgb_d = '0;
      end else if (pix_on) begin
        rgb_d = fg_active_q;
      end else begin
        rgb_d = BG_COLOR;
      end
      hsync_d = ctl_out.hsync;
      vsync_d = ctl_out.vsync;
      valid_d = ctl_out.video_on;
    end
  end

  always_comb begin
    fg_shadow_d = fg_shadow_q;
    fg_active_d = fg_active_q;
    pending_d   = pending_q;
    if (color_load) begin
      fg_shadow_d = color_fg_in;
      pending_d   = 1'b1;
    end
    if (frame_edge) begin
      if (color_load) begin
        fg_active_d = color_fg_in;
        pending_d   = 1'b0;
      end else if (pending_q) begin
        fg_active_d = fg_shadow_q;
        pending_d   = 1'b0;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (frame_edge) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = !blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q       <= '0;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      valid_q     <= 1'b0;
      fg_active_q <= FG_DEFAULT;
      fg_shadow_q <= FG_DEFAULT;
      pending_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      valid_q     <= valid_d;
      fg_active_q <= fg_active_d;
      fg_shadow_q <= fg_shadow_d;
      pending_q   <= pending_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_valid = valid_q;

endmodule
